// File: rtl/bin_bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bin_bcd_seq_if
// Brief    : Handshake bundle for the iterative binary-to-BCD converter.
//            Input side carries the binary value with in_valid/in_ready.
//            Output side carries the packed BCD result, the overflow flag and
//            the leading-zero blanking mask with out_valid/out_ready.
// Revision : 1.0 - initial release
// ============================================================================
interface bin_bcd_seq_if #(
    parameter int BIN_W  = 24,
    parameter int DIGITS = 8
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  ovf;
    logic [DIGITS-1:0]     blank;

    // Converter side: consumes values, produces results.
    modport slave (
        input  in_valid,
        input  bin_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bcd_out,
        output ovf,
        output blank
    );

    // Environment side: supplies values, accepts results.
    modport master (
        output in_valid,
        output bin_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bcd_out,
        input  ovf,
        input  blank
    );

endinterface
`default_nettype wire

// File: rtl/bin_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_bcd_seq
// Brief    : Iterative shift-and-add-3 binary-to-BCD converter. One input bit
//            is consumed per clock; the result is modulo 10^DIGITS with a
//            sticky overflow flag and a leading-zero blanking mask.
// Revision : 1.0 - initial release
// ============================================================================
module bin_bcd_seq #(
    parameter int BIN_W  = 24,
    parameter int DIGITS = 8
) (
    input  wire            clk,
    input  wire            rst_n,
    bin_bcd_seq_if.slave   bus
);

    localparam int c_CNT_W = $clog2(BIN_W + 1);
    localparam int c_BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [BIN_W-1:0]     r_shift;
    logic [c_BCD_W-1:0]   r_bcd;
    logic                 r_sticky;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [c_BCD_W-1:0]   r_bcd_out;
    logic                 r_ovf;
    logic [DIGITS-1:0]    r_blank;

    logic [c_BCD_W-1:0]   w_adj;
    logic [c_BCD_W-1:0]   w_bcd_next;
    logic [BIN_W-1:0]     w_shift_next;
    logic                 w_carry_out;
    logic [DIGITS-1:0]    w_blank;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_in_ready;
    logic                 w_out_valid;

    // Add-3 correction per digit; digits are independent, no carry between them.
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            assign w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? (r_bcd[4*k +: 4] + 4'd3)
                                                               : r_bcd[4*k +: 4];
        end
    endgenerate

    // Shift {BCD, binary} left by one; the bit leaving the top digit marks overflow.
    assign w_bcd_next   = {w_adj[c_BCD_W-2:0], r_shift[BIN_W-1]};
    assign w_shift_next = r_shift << 1;
    assign w_carry_out  = w_adj[c_BCD_W-1];

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_last   = (r_state == S_CONV) && (r_cnt == c_CNT_W'(1));

    // Blanking mask: a digit blanks when it and every digit above it are zero;
    // the ones digit is always shown so a zero result still displays "0".
    always_comb begin
        logic v_zero_above;
        w_blank      = '0;
        v_zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            v_zero_above = v_zero_above && (w_bcd_next[4*k +: 4] == 4'd0);
            w_blank[k]   = v_zero_above;
        end
        w_blank[0] = 1'b0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode; outputs come from state only.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                if (w_last) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Working datapath: load on acceptance, iterate while converting,
    // register the result on the final iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bcd     <= '0;
            r_sticky  <= 1'b0;
            r_cnt     <= '0;
            r_bcd_out <= '0;
            r_ovf     <= 1'b0;
            r_blank   <= ~DIGITS'(1);
        end else begin
            if (w_accept) begin
                r_shift  <= bus.bin_in;
                r_bcd    <= '0;
                r_sticky <= 1'b0;
                r_cnt    <= c_CNT_W'(BIN_W);
            end else if (r_state == S_CONV) begin
                r_shift  <= w_shift_next;
                r_bcd    <= w_bcd_next;
                r_sticky <= r_sticky | w_carry_out;
                r_cnt    <= r_cnt - c_CNT_W'(1);
                if (w_last) begin
                    r_bcd_out <= w_bcd_next;
                    r_ovf     <= r_sticky | w_carry_out;
                    r_blank   <= w_blank;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.bcd_out   = r_bcd_out;
    assign bus.ovf       = r_ovf;
    assign bus.blank     = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_bin_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_bcd_seq
// Brief    : Scoreboard bench for bin_bcd_seq: a 24-bit/8-digit instance and
//            an 8-bit/2-digit instance for truncation and overflow cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_bcd_seq;

    logic clk;
    logic rst_n;

    bin_bcd_seq_if #(.BIN_W(24), .DIGITS(8)) if24 ();
    bin_bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) if8  ();

    bin_bcd_seq #(.BIN_W(24), .DIGITS(8)) u_dut24 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if24.slave)
    );

    bin_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        logic [7:0]  blank;
    } exp_t;

    exp_t q24[$];
    exp_t q8[$];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check goes through here.
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Result monitors: pop an expectation whenever a result is handed over.
    always @(negedge clk) begin
        if (rst_n && if24.out_valid && if24.out_ready) begin
            if (q24.size() == 0) begin
                check("out24_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q24.pop_front();
                check("out24_bcd",   64'(if24.bcd_out), 64'(e.bcd));
                check("out24_ovf",   64'(if24.ovf),     64'(e.ovf));
                check("out24_blank", 64'(if24.blank),   64'(e.blank));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && if8.out_valid && if8.out_ready) begin
            if (q8.size() == 0) begin
                check("out8_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("out8_bcd",   64'(if8.bcd_out), 64'(e.bcd[7:0]));
                check("out8_ovf",   64'(if8.ovf),     64'(e.ovf));
                check("out8_blank", 64'(if8.blank),   64'(e.blank[1:0]));
            end
        end
    end

    task automatic check_reset24(input string tag);
        check({tag, "_in_ready"},  64'(if24.in_ready),  64'd1);
        check({tag, "_out_valid"}, 64'(if24.out_valid), 64'd0);
        check({tag, "_bcd"},       64'(if24.bcd_out),   64'd0);
        check({tag, "_ovf"},       64'(if24.ovf),       64'd0);
        check({tag, "_blank"},     64'(if24.blank),     64'hFE);
    endtask

    // Offer a value once the converter is idle; optionally record the expectation.
    task automatic send24(input logic [23:0] v, input logic [31:0] eb,
                          input logic [7:0] bl, input bit push);
        int n;
        exp_t e;
        n = 0;
        while (!if24.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("send24_ready", 64'(if24.in_ready), 64'd1);
        if24.in_valid = 1'b1;
        if24.bin_in   = v;
        e.bcd = eb; e.ovf = 1'b0; e.blank = bl;
        if (push) q24.push_back(e);
        @(posedge clk); #1;
        if24.in_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] v, input logic [7:0] eb,
                         input logic eo, input logic [1:0] bl);
        int n;
        exp_t e;
        n = 0;
        while (!if8.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("send8_ready", 64'(if8.in_ready), 64'd1);
        if8.in_valid = 1'b1;
        if8.bin_in   = v;
        e.bcd = {24'd0, eb}; e.ovf = eo; e.blank = {6'd0, bl};
        q8.push_back(e);
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
    endtask

    // Count edges until a result is presented (called one step after acceptance).
    task automatic wait24(output int n);
        n = 0;
        while (!if24.out_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("wait24_out_valid", 64'(if24.out_valid), 64'd1);
    endtask

    task automatic wait8(output int n);
        n = 0;
        while (!if8.out_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("wait8_out_valid", 64'(if8.out_valid), 64'd1);
    endtask

    // Directed stimulus.
    initial begin
        int lat;
        int t1;
        int t2;
        logic [7:0]  v8   [5] = '{8'd99, 8'd100, 8'd255, 8'd5, 8'd0};
        logic [7:0]  e8   [5] = '{8'h99, 8'h00,  8'h55,  8'h05, 8'h00};
        logic        o8   [5] = '{1'b0,  1'b1,   1'b1,   1'b0,  1'b0};
        logic [1:0]  b8   [5] = '{2'b00, 2'b10,  2'b00,  2'b10, 2'b10};

        rst_n         = 1'b0;
        if24.in_valid = 1'b0;
        if24.bin_in   = '0;
        if24.out_ready = 1'b1;
        if8.in_valid  = 1'b0;
        if8.bin_in    = '0;
        if8.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_reset24("reset24");
        check("reset8_blank", 64'(if8.blank), 64'h2);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Truncation / overflow on the narrow instance.
        for (int i = 0; i < 5; i++) begin
            send8(v8[i], e8[i], o8[i], b8[i]);
            wait8(lat);
            check("lat8", 64'(lat), 64'd8);
            @(posedge clk); #1;
        end

        // Zero and full-scale on the wide instance, with CONV length check.
        send24(24'd0, 32'h0000_0000, 8'hFE, 1'b1);
        wait24(lat);
        check("lat24_zero", 64'(lat), 64'd24);
        @(posedge clk); #1;

        send24(24'd16777215, 32'h1677_7215, 8'h00, 1'b1);
        wait24(lat);
        check("lat24_full", 64'(lat), 64'd24);
        @(posedge clk); #1;

        // Backpressure: result must stay put; a stray in_valid is ignored.
        if24.out_ready = 1'b0;
        send24(24'd1234, 32'h0000_1234, 8'hF0, 1'b1);
        wait24(lat);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                if24.in_valid = 1'b1;
                if24.bin_in   = 24'd999;
            end
            if (c == 4) if24.in_valid = 1'b0;
            check("hold_stable",
                  {22'd0, if24.out_valid, if24.in_ready, if24.bcd_out, if24.blank},
                  {22'd0, 1'b1, 1'b0, 32'h0000_1234, 8'hF0});
            @(posedge clk); #1;
        end
        if24.out_ready = 1'b1;
        @(posedge clk); #1;
        check("after_hs_idle",  64'({if24.in_ready, if24.out_valid}), 64'b10);
        check("after_hs_hold",  64'(if24.bcd_out), 64'h0000_1234);
        @(posedge clk); #1;
        check("stray_ignored",  64'(if24.in_ready), 64'd1);

        // Back-to-back with in_valid and out_ready held high.
        begin
            exp_t e;
            if24.in_valid = 1'b1;
            if24.bin_in   = 24'd7;
            e.bcd = 32'h0000_0007; e.ovf = 1'b0; e.blank = 8'hFE;
            q24.push_back(e);
            @(posedge clk); #1;
            if24.bin_in = 24'd42;
            e.bcd = 32'h0000_0042; e.ovf = 1'b0; e.blank = 8'hFC;
            q24.push_back(e);
        end
        wait24(lat);
        t1 = lat;
        @(posedge clk); #1;
        check("b2b_in_ready_pulse", 64'({if24.in_ready, if24.out_valid}), 64'b10);
        @(posedge clk); #1;
        check("b2b_second_accept", 64'(if24.in_ready), 64'd0);
        if24.in_valid = 1'b0;
        wait24(lat);
        t2 = lat + 2;
        check("b2b_spacing", 64'(t2), 64'd26);
        check("b2b_first_lat", 64'(t1), 64'd24);
        @(posedge clk); #1;

        // Reset during conversion: outputs drop to reset values at once.
        send24(24'd1234, 32'h0000_1234, 8'hF0, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset24("midconv_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send24(24'd500, 32'h0000_0500, 8'hF8, 1'b1);
        wait24(lat);
        check("lat24_after_rst", 64'(lat), 64'd24);

        repeat (4) @(posedge clk);
        #1;
        check("q24_drained", 64'(q24.size()), 64'd0);
        check("q8_drained",  64'(q8.size()),  64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/bin_bcd_seq.md
Name: bin_bcd_seq

Overview:
Parametrised, iterative binary-to-BCD converter using shift-and-add-3. It processes one input bit per clock and replaces the single-cycle unrolled converter. The input is accepted on a valid/ready handshake, and the packed BCD result is held on a valid/ready output. It also adds an overflow flag and a leading-zero blanking mask. It sits between value sources (switch scaling, counters, measurement logic) and the seven-segment display driver.

Parameters:
BIN_W, 24, width of the unsigned binary input; must be >= 1.
DIGITS, 8, number of BCD digits produced; must be >= 1. Results are modulo 10^DIGITS.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  bin_in is valid.
in_ready  output  1  block is idle and can accept a value.
bin_in  input  BIN_W  unsigned binary value.
out_valid  output  1  bcd_out/ovf/blank are valid.
out_ready  input  1  consumer accepts the result.
bcd_out  output  4*DIGITS  packed BCD; digit k is bits [4k+3:4k]; digit 0 is ones.
ovf  output  1  input value >= 10^DIGITS.
blank  output  DIGITS  bit k = 1 when digit k and all higher digits are zero; bit 0 is always 0.

Behaviour:
- Reset, asynchronous, any state:
  - state=IDLE; in_ready=1; out_valid=0; bcd_out=0; ovf=0.
  - blank = all ones except bit 0; internal shift, BCD and counter registers = 0.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready at edge E0: capture bin_in into the shift register, clear the working BCD register and sticky overflow, load bit counter = BIN_W, go to CONV.
  - CONV: in_ready=0. Each edge performs one iteration:
    - every working digit >= 5 gets +3 (4-bit, no carry between digits);
    - the whole {BCD, shift} vector shifts left by 1, MSB of bin_in first;
    - the bit shifted out of the top digit's MSB ORs into the sticky overflow;
    - counter decrements.
    - At the edge where counter reaches 0 (edge E0+BIN_W): bcd_out <= final working BCD; ovf <= sticky overflow; blank <= computed mask; out_valid <= 1; go to HOLD.
  - HOLD: out_valid=1, in_ready=0. bcd_out, ovf and blank are stable. On out_valid && out_ready: out_valid <= 0, go to IDLE. in_ready rises the cycle after.
- Latency: out_valid is high after edge E0+BIN_W. Minimum throughput is one conversion per BIN_W+2 cycles, assuming out_ready is held high.
- Overflow truncation:
  - the digits hold value mod 10^DIGITS, and ovf=1 iff value >= 10^DIGITS;
  - when ovf=1, blank is computed on the truncated digits.
- in_valid while not in IDLE is ignored; bin_in is sampled only at acceptance.
- bcd_out, ovf and blank hold their last values after the handshake completes, until the next result is registered.
- out_ready is ignored outside HOLD.
- Reset mid-CONV or mid-HOLD: the conversion is abandoned, no out_valid pulse is produced, and all outputs return to reset values.
- Counter width is clog2(BIN_W+1). All arithmetic is unsigned. No combinational path from inputs to outputs.

Test Plan:
- Zero input (defaults): bin_in=0 accepted at E0 -> out_valid after E0+24; bcd_out=0x00000000; ovf=0; blank=8'b1111_1110.
- Full-scale input (defaults): bin_in=16777215 -> bcd_out=0x16777215; ovf=0; blank=0; exactly 24 cycles in CONV.
- Truncation and overflow (BIN_W=8, DIGITS=2), one case per conversion:
  - 99 -> bcd_out=0x99, ovf=0;
  - 100 -> bcd_out=0x00, ovf=1, blank=2'b10;
  - 255 -> bcd_out=0x55, ovf=1.
- Backpressure: 1234 converted with out_ready=0 for 10 cycles -> bcd_out=0x00001234 and blank=8'b1111_0000 stable; in_ready=0 throughout; a second in_valid in that window is ignored.
- Back-to-back: 7 then 42 with in_valid and out_ready held high -> two results 0x00000007 and 0x00000042, in_ready pulses between them, spacing 26 cycles.
- Reset mid-CONV: assert rst_n=0 at iteration 10 -> all outputs return to reset immediately (asynchronously). After release, a fresh 500 -> 0x00000500.
